// File: rtl/uart_wb_master.sv
// -----------------------------------------------------------------------------
// uart_wb_master
//
// Byte-stream to Wishbone classic initiator. Command frames arrive on a
// receive byte stream, each one turns into a single Wishbone read or write
// cycle, and a short response goes back out on a transmit byte stream.
//
// Frames (multi-byte fields MSB first):
//   write : 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0   -> response 0x4B 'K'
//   read  : 0x52 'R', A3 A2 A1 A0                -> response D3 D2 D1 D0
//   other : any other command byte               -> response 0x3F '?'
//
// Handshakes: a byte moves on a clock edge where valid && ready are both
// high. The producer holds valid and data steady until that edge. This holds
// for rx_* (upstream drives valid/data, this block drives ready) and for
// tx_* (this block drives valid/data, the transmitter drives ready).
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   rx_data_i/valid_i/ready_o receive byte stream (commands in)
//   tx_data_o/valid_o/ready_i transmit byte stream (responses out)
//   wbm_*                    Wishbone classic initiator port
//   busy_o                   high whenever the FSM is not idle
//
// Optional feature, macro WB_TIMEOUT_EN:
//   Adds parameter TIMEOUT_CYCLES (default 255). A bus cycle that sees no ack
//   after TIMEOUT_CYCLES strobe cycles is abandoned and answered with 0x45
//   'E'. An ack on the final allowed cycle still wins. Without the macro the
//   bus cycle waits for ack indefinitely.
// -----------------------------------------------------------------------------
module uart_wb_master
`ifdef WB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;
`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] RSP_ERR   = 8'h45;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  cnt;          // byte index within a 4-byte field; wrap ends the field
  logic        resp_single;  // response is one status byte rather than 4 data bytes
  logic [31:0] rdata;        // remaining read-data bytes, next one in [31:24]
  logic        rx_fire;
  logic        tx_fire;
  logic        bus_ack;

  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  // ack only counts while the strobe is actually up
  assign bus_ack = wbm_stb_o && wbm_ack_i;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          timed_out;

  // to_cnt equals the number of strobe cycles already completed without ack,
  // so it hits TO_LAST during the TIMEOUT_CYCLES-th strobe cycle.
  assign timed_out = (to_cnt == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state != S_BUS)) begin
      to_cnt <= '0;
    end else if (!timed_out) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      resp_single <= 1'b0;
      rdata       <= 32'h0;
      rx_ready_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      tx_valid_o  <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0;
      wbm_dat_o   <= 32'h0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // ready comes up one cycle after reset release and stays up here
          rx_ready_o <= 1'b1;
          if (rx_fire) begin
            busy_o <= 1'b1;
            if ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)) begin
              wbm_we_o <= (rx_data_i == CMD_WRITE);
              cnt      <= 2'd0;
              state    <= S_ADDR;
            end else begin
              rx_ready_o  <= 1'b0;
              tx_data_o   <= RSP_BAD;
              tx_valid_o  <= 1'b1;
              resp_single <= 1'b1;
              state       <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            wbm_adr_o <= {wbm_adr_o[23:0], rx_data_i};
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (wbm_we_o) begin
                state <= S_DATA;
              end else begin
                rx_ready_o <= 1'b0;
                wbm_cyc_o  <= 1'b1;
                wbm_stb_o  <= 1'b1;
                wbm_sel_o  <= 4'hF;
                state      <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            wbm_dat_o <= {wbm_dat_o[23:0], rx_data_i};
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              rx_ready_o <= 1'b0;
              wbm_cyc_o  <= 1'b1;
              wbm_stb_o  <= 1'b1;
              wbm_sel_o  <= 4'hF;
              state      <= S_BUS;
            end
          end
        end

        S_BUS: begin
          if (bus_ack) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_sel_o  <= 4'h0;
            tx_valid_o <= 1'b1;
            cnt        <= 2'd0;
            state      <= S_RESP;
            if (wbm_we_o) begin
              tx_data_o   <= RSP_OK;
              resp_single <= 1'b1;
            end else begin
              // first byte goes straight out, the rest queue up in rdata
              tx_data_o   <= wbm_dat_i[31:24];
              rdata       <= {wbm_dat_i[23:0], 8'h00};
              resp_single <= 1'b0;
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (timed_out) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_sel_o   <= 4'h0;
            tx_data_o   <= RSP_ERR;
            tx_valid_o  <= 1'b1;
            resp_single <= 1'b1;
            state       <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          if (tx_fire) begin
            if (resp_single || (cnt == 2'd3)) begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= S_IDLE;
            end else begin
              tx_data_o <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
              cnt       <= cnt + 2'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_master
//
// Self-checking bench for uart_wb_master. A Wishbone responder process acks
// each cycle after a programmable number of strobe cycles and logs every bus
// transaction; a transmit monitor collects every accepted response byte. A
// reference model turns each command frame into the bus transaction and the
// response bytes it should produce. Define WB_TIMEOUT_EN to also exercise
// the bus timeout (instantiated with TIMEOUT_CYCLES = 8).
// -----------------------------------------------------------------------------
module tb_uart_wb_master;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // DUT signals
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack   = 1'b0;
  logic        busy;

`ifdef WB_TIMEOUT_EN
  uart_wb_master #(.TIMEOUT_CYCLES(8)) dut (
`else
  uart_wb_master dut (
`endif
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack),
    .busy_o    (busy)
  );

  // counters
  int asserts  = 0;
  int failures = 0;

  // scoreboard: expected and observed response bytes / bus transactions
  logic [7:0]  exp_q[$];
  logic [7:0]  got_tx[$];
  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  logic        exp_we_q[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];

  // responder controls and observations
  int          ack_delay    = 0;
  bit          never_ack    = 0;
  logic [31:0] slave_rdata  = 32'h0;
  bit          rand_ready   = 0;
  int          bus_count    = 0;
  int          stb_cycles   = 0;
  int          last_stb_len = 0;
  int          stable_err   = 0;

  // Wishbone responder: acts just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      ack        = 1'b0;
      stb_cycles = 0;
    end else if (cyc && stb) begin
      if (stb_cycles == 0) begin
        bus_count++;
        log_adr.push_back(adr);
        log_dat.push_back(dat_o);
        log_we.push_back(we);
        log_sel.push_back(sel);
      end else if (log_adr.size() > 0) begin
        if (adr !== log_adr[$] || dat_o !== log_dat[$] || we !== log_we[$] || sel !== log_sel[$])
          stable_err++;
      end
      ack   = (!never_ack && stb_cycles == ack_delay);
      dat_i = ack ? slave_rdata : 32'h0;
      stb_cycles++;
      last_stb_len = stb_cycles;
    end else begin
      ack        = 1'b0;
      stb_cycles = 0;
    end
  end

  // random transmit backpressure
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  // transmit monitor: the byte is taken on the next rising edge
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got_tx.push_back(tx_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // reference model: what a frame must do on the bus and on the tx stream
  // ---------------------------------------------------------------------------
  function automatic void model_frame(input logic [7:0] cmd, input logic [31:0] a,
                                      input logic [31:0] d, input logic [31:0] rd,
                                      input bit no_ack);
    if (cmd == CMD_W || cmd == CMD_R) begin
      exp_adr_q.push_back(a);
      exp_dat_q.push_back(d);
      exp_we_q.push_back(cmd == CMD_W);
      if (no_ack) exp_q.push_back(8'h45);
      else if (cmd == CMD_W) exp_q.push_back(8'h4B);
      else for (int i = 3; i >= 0; i--) exp_q.push_back(rd[i*8 +: 8]);
    end else begin
      exp_q.push_back(8'h3F);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // driver tasks (entered and left just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic clear_logs();
    exp_q.delete();     got_tx.delete();
    exp_adr_q.delete(); exp_dat_q.delete(); exp_we_q.delete();
    log_adr.delete();   log_dat.delete();   log_we.delete(); log_sel.delete();
    stable_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready) begin
      n++;
      if (n > 1000) begin
        asserts++; failures++;
        $display("FAIL rx_accept: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    send_byte(cmd);
    if (cmd == CMD_W || cmd == CMD_R)
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (cmd == CMD_W)
      for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy) begin
      n++;
      if (n > 2000) begin
        asserts++; failures++;
        $display("FAIL %s_idle: busy_o=%b after %0d cycles, required 0", name, busy, n);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++; if ({cyc, stb, we, tx_valid, rx_ready, busy} !== 6'b0) begin failures++;
      $display("FAIL reset_ctrl: cyc/stb/we/tx_valid/rx_ready/busy=%b required 000000",
               {cyc, stb, we, tx_valid, rx_ready, busy}); end
    asserts++; if (sel !== 4'h0 || tx_data !== 8'h00) begin failures++;
      $display("FAIL reset_sel_tx: sel=%h tx_data=%h required 0/00", sel, tx_data); end
    asserts++; if (adr !== 32'h0 || dat_o !== 32'h0) begin failures++;
      $display("FAIL reset_regs: adr=%h dat=%h required 0/0", adr, dat_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    asserts++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_release: rx_ready=%b busy=%b required 1/0", rx_ready, busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int bc;
    clear_logs();
    bc = bus_count;
    ack_delay = 2;
    model_frame(CMD_W, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 0);
    send_frame(CMD_W, 32'h3000_0004, 32'hDEAD_BEEF);
    @(negedge clk);
    asserts++; if (cyc !== 1'b1 || stb !== 1'b1) begin failures++;
      $display("FAIL write_cyc_rise: cyc=%b stb=%b required 1/1", cyc, stb); end
    @(posedge clk);
    #1;
    wait_idle("write");
    asserts++; if (bus_count - bc !== 1) begin failures++;
      $display("FAIL write_cycles: %0d bus cycles, required 1", bus_count - bc); end
    else begin
      asserts++; if (log_adr[0] !== exp_adr_q[0] || log_dat[0] !== exp_dat_q[0]) begin failures++;
        $display("FAIL write_adr_dat: adr=%h dat=%h required %h/%h",
                 log_adr[0], log_dat[0], exp_adr_q[0], exp_dat_q[0]); end
      asserts++; if (log_we[0] !== exp_we_q[0] || log_sel[0] !== 4'hF) begin failures++;
        $display("FAIL write_we_sel: we=%b sel=%h required %b/f", log_we[0], log_sel[0], exp_we_q[0]); end
    end
    asserts++; if (last_stb_len !== 3 || stable_err !== 0) begin failures++;
      $display("FAIL write_stb: stb cycles=%0d unstable=%0d required 3/0", last_stb_len, stable_err); end
    asserts++; if (got_tx.size() !== 1 || got_tx[0] !== exp_q[0]) begin failures++;
      $display("FAIL write_resp: %0d bytes first=%h required 1 byte %h",
               got_tx.size(), (got_tx.size() > 0) ? got_tx[0] : 8'hxx, exp_q[0]); end
  endtask

  task automatic test_read();
    int hs = 0;
    int n  = 0;
    clear_logs();
    ack_delay   = 1;
    slave_rdata = 32'h1234_5678;
    model_frame(CMD_R, 32'h3000_0000, 32'h0, slave_rdata, 0);
    send_frame(CMD_R, 32'h3000_0000, 32'h0);
    while (hs < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (tx_valid && tx_ready) hs++;
    end
    asserts++; if (hs !== 4) begin failures++;
      $display("FAIL read_handshakes: %0d, required 4", hs); end
    asserts++; if (busy !== 1'b1) begin failures++;
      $display("FAIL read_busy_last: busy=%b during last byte, required 1", busy); end
    @(negedge clk);
    asserts++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin failures++;
      $display("FAIL read_busy_drop: busy=%b tx_valid=%b required 0/0", busy, tx_valid); end
    @(posedge clk);
    #1;
    asserts++; if (log_we.size() !== 1 || log_we[0] !== 1'b0 || log_adr[0] !== exp_adr_q[0]) begin
      failures++;
      $display("FAIL read_bus: %0d cycles, required one read at %h", log_we.size(), exp_adr_q[0]); end
    asserts++; if (got_tx.size() !== exp_q.size()) begin failures++;
      $display("FAIL read_len: %0d bytes, required %0d", got_tx.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      asserts++; if (got_tx[i] !== exp_q[i]) begin failures++;
        $display("FAIL read_byte%0d: %h required %h", i, got_tx[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_cmd();
    int bc;
    clear_logs();
    bc = bus_count;
    model_frame(8'hA5, 32'h0, 32'h0, 32'h0, 0);
    send_byte(8'hA5);
    wait_idle("bad");
    asserts++; if (bus_count !== bc) begin failures++;
      $display("FAIL bad_no_cycle: %0d bus cycles, required 0", bus_count - bc); end
    asserts++; if (got_tx.size() !== 1 || got_tx[0] !== exp_q[0]) begin failures++;
      $display("FAIL bad_resp: %0d bytes, required one %h", got_tx.size(), exp_q[0]); end
    clear_logs();
    slave_rdata = $urandom();
    model_frame(CMD_R, 32'h3000_0100, 32'h0, slave_rdata, 0);
    send_frame(CMD_R, 32'h3000_0100, 32'h0);
    wait_idle("bad_next");
    asserts++; if (got_tx != exp_q || log_adr.size() !== 1) begin failures++;
      $display("FAIL bad_next_read: %0d bytes %0d cycles, required 4 bytes 1 cycle",
               got_tx.size(), log_adr.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_logs();
    ack_delay   = 0;
    slave_rdata = 32'h1234_5678;
    tx_ready    = 1'b0;
    model_frame(CMD_R, 32'h3000_0008, 32'h0, slave_rdata, 0);
    send_frame(CMD_R, 32'h3000_0008, 32'h0);
    @(negedge clk);
    while (!tx_valid && n < 100) begin n++; @(negedge clk); end
    for (int c = 0; c < 10; c++) begin
      asserts++; if (tx_data !== exp_q[0] || tx_valid !== 1'b1 || rx_ready !== 1'b0) begin failures++;
        $display("FAIL bp_hold%0d: tx_data=%h valid=%b rx_ready=%b required %h/1/0",
                 c, tx_data, tx_valid, rx_ready, exp_q[0]); end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle("bp");
    asserts++; if (got_tx != exp_q) begin failures++;
      $display("FAIL bp_resp: %0d bytes first=%h required %0d bytes from %h",
               got_tx.size(), (got_tx.size() > 0) ? got_tx[0] : 8'hxx, exp_q.size(), exp_q[0]); end
  endtask

  task automatic test_reset_mid();
    int bc;
    clear_logs();
    bc = bus_count;
    ack_delay = 1;
    send_byte(CMD_W);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    asserts++; if ({cyc, stb, tx_valid, rx_ready, busy} !== 5'b0) begin failures++;
      $display("FAIL rstmid_outputs: cyc/stb/tx_valid/rx_ready/busy=%b required 00000",
               {cyc, stb, tx_valid, rx_ready, busy}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_frame(CMD_W, 32'h3000_0010, 32'h0BAD_F00D, 32'h0, 0);
    send_frame(CMD_W, 32'h3000_0010, 32'h0BAD_F00D);
    wait_idle("rstmid");
    asserts++; if (bus_count - bc !== 1) begin failures++;
      $display("FAIL rstmid_cycles: %0d, required 1", bus_count - bc); end
    else begin
      asserts++; if (log_adr[0] !== exp_adr_q[0] || log_dat[0] !== exp_dat_q[0] || log_we[0] !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_bus: adr=%h dat=%h we=%b required %h/%h/1",
                 log_adr[0], log_dat[0], log_we[0], exp_adr_q[0], exp_dat_q[0]); end
    end
    asserts++; if (got_tx != exp_q) begin failures++;
      $display("FAIL rstmid_resp: %0d bytes, required one %h", got_tx.size(), exp_q[0]); end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [31:0] a, d;
    int          k;
    rand_ready = 1;
    for (int f = 0; f < 24; f++) begin
      clear_logs();
      k = $urandom_range(0, 4);
      if (k < 2) cmd = CMD_W;
      else if (k < 4) cmd = CMD_R;
      else begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == CMD_W || cmd == CMD_R) cmd = 8'hFF;
      end
      a           = $urandom();
      d           = $urandom();
      ack_delay   = $urandom_range(0, 5);
      slave_rdata = $urandom();
      model_frame(cmd, a, d, slave_rdata, 0);
      send_frame(cmd, a, d);
      wait_idle("rand");
      asserts++; if (log_adr.size() !== exp_adr_q.size()) begin failures++;
        $display("FAIL rand%0d_cycles: %0d, required %0d", f, log_adr.size(), exp_adr_q.size()); end
      else for (int i = 0; i < exp_adr_q.size(); i++) begin
        asserts++;
        if (log_adr[i] !== exp_adr_q[i] || log_we[i] !== exp_we_q[i] || log_sel[i] !== 4'hF ||
            (exp_we_q[i] && log_dat[i] !== exp_dat_q[i])) begin failures++;
          $display("FAIL rand%0d_bus: adr=%h we=%b sel=%h dat=%h required %h/%b/f/%h",
                   f, log_adr[i], log_we[i], log_sel[i], log_dat[i],
                   exp_adr_q[i], exp_we_q[i], exp_dat_q[i]); end
      end
      asserts++; if (got_tx != exp_q || stable_err !== 0) begin failures++;
        $display("FAIL rand%0d_resp: %0d bytes unstable=%0d required %0d bytes stable",
                 f, got_tx.size(), stable_err, exp_q.size()); end
    end
    rand_ready = 0;
    tx_ready   = 1'b1;
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    never_ack = 1;
    model_frame(CMD_R, 32'h3000_0020, 32'h0, 32'h0, 1);
    send_frame(CMD_R, 32'h3000_0020, 32'h0);
    wait_idle("timeout");
    never_ack = 0;
    asserts++; if (last_stb_len !== 8) begin failures++;
      $display("FAIL timeout_stb: stb high %0d cycles, required 8", last_stb_len); end
    asserts++; if (got_tx != exp_q) begin failures++;
      $display("FAIL timeout_resp: %0d bytes, required one %h", got_tx.size(), exp_q[0]); end
    // ack on the last allowed cycle must still give a normal read response
    clear_logs();
    ack_delay   = 7;
    slave_rdata = 32'hCAFE_0123;
    model_frame(CMD_R, 32'h3000_0024, 32'h0, slave_rdata, 0);
    send_frame(CMD_R, 32'h3000_0024, 32'h0);
    wait_idle("ack_edge");
    asserts++; if (last_stb_len !== 8 || got_tx != exp_q) begin failures++;
      $display("FAIL timeout_ack_wins: stb=%0d bytes=%0d required 8/%0d",
               last_stb_len, got_tx.size(), exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
